latch_sample_accum: RTL and testbench
=====================================

Name: latch_sample_accum

Overview:
- Downstream consumer of the level-sensitive increment latch stage. That stage produces a 3-bit value that is transparent while its enable is high and frozen once the enable drops.
- This block detects the closing edge of that enable and samples the frozen value into a synchronous accumulator.
- After NSAMP samples it presents the sum on a valid/ready output handshake.
- It is the first clocked stage after the latch, so latch-based results can be checked in a flop-based test harness.

Parameters:
- DATA_W, 3, width of the sampled latch output.
- NSAMP, 4, samples per accumulation window; legal range 2..16.
- SUM_W, DATA_W+$clog2(NSAMP), accumulator and result width. With defaults this is 5 bits, max 7*4=28, so no overflow is possible.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sample_en  input  1  enable of the upstream latch, synchronous to clk.
- sample_in  input  DATA_W  upstream latch output; stable whenever sample_en is low.
- clr  input  1  synchronous abort of the current window.
- sum_out  output  SUM_W  accumulated result, held while sum_valid is high.
- sum_valid  output  1  result available.
- sum_ready  input  1  consumer accepts the result.
- busy  output  1  high in the ACCUM state.
- overrun  output  1  sticky; a capture was dropped while in DONE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, acc=0, cnt=0, en_q=0.
  - sum_out=0, sum_valid=0, busy=0, overrun=0.
- Capture pulse:
  - cap = en_q & ~sample_en, where en_q is sample_en registered one cycle.
  - A 1-cycle high-low pattern yields exactly one cap.
  - sample_en held high yields no cap.
- IDLE:
  - cap: acc<=sample_in, cnt<=1, go to ACCUM.
  - If NSAMP==1 is ever allowed by a future change, go straight to DONE.
- ACCUM (busy=1):
  - cap: acc<=acc+sample_in, cnt<=cnt+1.
  - When cnt==NSAMP-1 at cap: sum_out<=acc+sample_in, go to DONE.
  - sum_valid rises on the clock edge that registers the NSAMP-th cap, i.e. 1 cycle after the cycle where cap is high.
- DONE (sum_valid=1, sum_out stable):
  - sum_ready high: handshake completes; sum_valid drops next edge; overrun clears.
    - If cap is also high in that cycle: acc<=sample_in, cnt<=1, go to ACCUM (sample not lost).
    - Otherwise go to IDLE.
  - sum_ready low and cap high: sample dropped, overrun<=1, stay in DONE.
- clr:
  - Highest priority after reset; any state goes to IDLE, acc=0, cnt=0, sum_valid=0.
  - overrun clears.
  - A cap in the same cycle is ignored.
  - en_q still updates, so no spurious cap follows.
- sum_out:
  - Holds its last value in IDLE/ACCUM; only updated on the DONE transition.
- Arithmetic:
  - Unsigned; sample_in is zero-extended to SUM_W before the add; no wrap by construction.
- Reset asserted mid-window: all state cleared immediately; no partial sum emitted after release.
- sample_en high at reset release: en_q=0, so no cap until a later high-low transition.

Decomposition:
- Package latch_accum_pkg:
  - state enum {IDLE, ACCUM, DONE}.
  - localparam helper for SUM_W.
  - Counter width CNT_W=$clog2(NSAMP+1).
- Sub-module en_fall_detect: clk, rst_n, sample_en in; cap out. It holds the en_q register and edge logic and is reused by other latch-fed stages.
- FSM, accumulator and handshake stay in the top module.

Test Plan:
- Basic window: 4 sample_en pulses with sample_in=1,2,3,4 (sum_ready=1) -> sum_valid high for 1 cycle, starting the edge after the 4th cap, sum_out=10; busy high between cap1 and cap4; state returns to IDLE.
- Backpressure: 4 captures of 7 with sum_ready=0 -> sum_out=28 held stable. Then a 5th pulse -> overrun=1, sum_out still 28. Then sum_ready=1 -> sum_valid drops, overrun clears.
- Back-to-back: in DONE, raise sum_ready in the same cycle as a cap with sample_in=5 -> handshake completes, state=ACCUM, acc=5, cnt=1. Three further caps of 1 -> sum_out=8.
- Held enable: sample_en high for 20 cycles with sample_in toggling -> no cap and no state change. Release -> exactly one cap using the value present at the fall.
- clr: after 2 caps (acc=3), assert clr together with a cap -> IDLE, acc=0. The next 4 caps of 2 -> sum_out=8.
- Async reset: assert rst_n low mid-ACCUM, between clock edges -> all outputs go to 0 immediately. Release with sample_en=1 -> no cap until sample_en falls.

Source files
------------

// File: rtl/latch_accum_pkg.sv
// Shared types and width helpers for stages fed by the level-sensitive increment latch.
package latch_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

  // Result width: worst case NSAMP full-scale samples fit without wrap.
  function automatic int sum_width(input int data_w, input int nsamp);
    return data_w + $clog2(nsamp);
  endfunction

  function automatic int cnt_width(input int nsamp);
    return $clog2(nsamp + 1);
  endfunction

endpackage

// File: rtl/en_fall_detect.sv
// Falling-edge detector on a latch enable: cap is high for one cycle after enable drops.
// Combinational cap from a single registered copy of the enable; no backpressure.
module en_fall_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_en,
  output logic cap
);

  logic en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_q <= 1'b0;
    else        en_q <= sample_en;
  end

  assign cap = en_q & ~sample_en;

endmodule

// File: rtl/latch_sample_accum.sv
// Samples the frozen latch value on each enable fall and sums NSAMP of them into a held result.
// Result valid one cycle after the last capture; captures arriving while the result is unaccepted are dropped and flagged.
module latch_sample_accum
  import latch_accum_pkg::*;
#(
  parameter int DATA_W = 3,
  parameter int NSAMP  = 4,
  parameter int SUM_W  = sum_width(DATA_W, NSAMP)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              clr,
  output logic [SUM_W-1:0]  sum_out,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic              busy,
  output logic              overrun
);

  localparam int CNT_W = cnt_width(NSAMP);

  acc_state_t       state_q, state_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             ovr_q, ovr_d;
  logic             cap;
  logic [SUM_W-1:0] sample_ext;
  logic [SUM_W-1:0] acc_sum;

  en_fall_detect u_fall (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample_en (sample_en),
    .cap       (cap)
  );

  assign sample_ext = SUM_W'(sample_in);
  assign acc_sum    = acc_q + sample_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    ovr_d   = ovr_q;

    // clr wins over any capture in the same cycle; sum_out keeps its last value.
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cap) begin
            acc_d = sample_ext;
            cnt_d = CNT_W'(1);
            if (NSAMP == 1) begin
              sum_d   = sample_ext;
              state_d = DONE;
            end else begin
              state_d = ACCUM;
            end
          end
        end
        ACCUM: begin
          if (cap) begin
            acc_d = acc_sum;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(NSAMP - 1)) begin
              sum_d   = acc_sum;
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (sum_ready) begin
            ovr_d = 1'b0;
            // A capture coinciding with the handshake opens the next window.
            if (cap) begin
              acc_d = sample_ext;
              cnt_d = CNT_W'(1);
              if (NSAMP == 1) begin
                sum_d   = sample_ext;
                state_d = DONE;
              end else begin
                state_d = ACCUM;
              end
            end else begin
              state_d = IDLE;
            end
          end else if (cap) begin
            ovr_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign sum_out   = sum_q;
  assign sum_valid = (state_q == DONE);
  assign busy      = (state_q == ACCUM);
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_latch_sample_accum.sv
// Bench for latch_sample_accum: directed scenarios plus randomized traffic against a window-list reference model.
module tb_latch_sample_accum;

  localparam int DATA_W = 3;
  localparam int NSAMP  = 4;
  localparam int SUM_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sample_en;
  logic [DATA_W-1:0] sample_in;
  logic              clr;
  logic [SUM_W-1:0]  sum_out;
  logic              sum_valid;
  logic              sum_ready;
  logic              busy;
  logic              overrun;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the open window is a list of captured values.
  int win[$];
  bit m_prev_en;
  bit m_valid;
  bit m_ovr;
  int m_sum;

  latch_sample_accum #(.DATA_W(DATA_W), .NSAMP(NSAMP), .SUM_W(SUM_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample_en (sample_en),
    .sample_in (sample_in),
    .clr       (clr),
    .sum_out   (sum_out),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic bit exp_busy();
    return !m_valid && (win.size() != 0);
  endfunction

  task automatic model_reset();
    win.delete();
    m_prev_en = 1'b0;
    m_valid   = 1'b0;
    m_ovr     = 1'b0;
    m_sum     = 0;
  endtask

  task automatic model_step();
    bit cap;
    cap = m_prev_en && !sample_en;
    if (clr) begin
      win.delete();
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end else if (m_valid) begin
      if (sum_ready) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        if (cap) win.push_back(int'(sample_in));
      end else if (cap) begin
        m_ovr = 1'b1;
      end
    end else if (cap) begin
      win.push_back(int'(sample_in));
      if (win.size() == NSAMP) begin
        m_sum   = win.sum();
        m_valid = 1'b1;
        win.delete();
      end
    end
    m_prev_en = sample_en;
  endtask

  // Advance one clock; inputs are applied before the call, outputs settle by return.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // One enable pulse: high for a cycle, then low for a cycle (capture registered on return).
  task automatic pulse(input logic [DATA_W-1:0] v);
    sample_en = 1'b1;
    sample_in = v;
    tick();
    sample_en = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sample_en = 1'b0; sample_in = '0; clr = 1'b0; sum_ready = 1'b1;
    model_reset();
    #12;
    n_cmp++;
    if ({sum_valid, busy, overrun, sum_out} !== {1'b0, 1'b0, 1'b0, 5'd0}) begin
      n_bad++;
      $display("FAIL reset_state: got v=%b b=%b o=%b s=%0d, want all zero", sum_valid, busy, overrun, sum_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_window();
    sum_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      pulse(DATA_W'(i));
      n_cmp++;
      if (i < 4 && (busy !== 1'b1 || sum_valid !== 1'b0)) begin
        n_bad++;
        $display("FAIL basic_busy[%0d]: got busy=%b valid=%b, want busy=1 valid=0", i, busy, sum_valid);
      end else if (i == 4 && (sum_valid !== 1'b1 || sum_out !== 5'd10 || busy !== 1'b0)) begin
        n_bad++;
        $display("FAIL basic_result: got valid=%b sum=%0d busy=%b, want valid=1 sum=10 busy=0", sum_valid, sum_out, busy);
      end
    end
    tick();
    n_cmp++;
    if (sum_valid !== 1'b0 || busy !== 1'b0 || sum_out !== 5'd10) begin
      n_bad++;
      $display("FAIL basic_idle: got valid=%b busy=%b sum=%0d, want valid=0 busy=0 sum=10", sum_valid, busy, sum_out);
    end
  endtask

  task automatic test_backpressure();
    sum_ready = 1'b0;
    for (int i = 0; i < 4; i++) pulse(3'd7);
    n_cmp++;
    if (sum_valid !== 1'b1 || sum_out !== 5'd28 || overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_result: got valid=%b sum=%0d ovr=%b, want valid=1 sum=28 ovr=0", sum_valid, sum_out, overrun);
    end
    pulse(3'd3);
    n_cmp++;
    if (sum_valid !== 1'b1 || sum_out !== 5'd28 || overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_overrun: got valid=%b sum=%0d ovr=%b, want valid=1 sum=28 ovr=1", sum_valid, sum_out, overrun);
    end
    sum_ready = 1'b1;
    tick();
    n_cmp++;
    if (sum_valid !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_accept: got valid=%b ovr=%b busy=%b, want 0 0 0", sum_valid, overrun, busy);
    end
  endtask

  task automatic test_back_to_back();
    sum_ready = 1'b0;
    for (int i = 0; i < 4; i++) pulse(3'd2);
    sample_en = 1'b1; sample_in = 3'd5;
    tick();
    sample_en = 1'b0; sum_ready = 1'b1;
    tick();
    n_cmp++;
    if (sum_valid !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_handoff: got valid=%b busy=%b, want valid=0 busy=1", sum_valid, busy);
    end
    for (int i = 0; i < 3; i++) pulse(3'd1);
    n_cmp++;
    if (sum_valid !== 1'b1 || sum_out !== 5'd8) begin
      n_bad++;
      $display("FAIL b2b_sum: got valid=%b sum=%0d, want valid=1 sum=8", sum_valid, sum_out);
    end
    tick();
  endtask

  task automatic test_held_enable();
    logic [DATA_W-1:0] v;
    sum_ready = 1'b1;
    sample_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sample_in = DATA_W'($urandom_range(0, 7));
      tick();
      n_cmp++;
      if (busy !== 1'b0 || sum_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL held_no_cap[%0d]: got busy=%b valid=%b, want 0 0", i, busy, sum_valid);
      end
    end
    v = DATA_W'($urandom_range(1, 7));
    sample_in = v;
    sample_en = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL held_release: got busy=%b, want 1", busy);
    end
    for (int i = 0; i < 3; i++) pulse(3'd0);
    n_cmp++;
    if (sum_valid !== 1'b1 || sum_out !== SUM_W'(v)) begin
      n_bad++;
      $display("FAIL held_value: got valid=%b sum=%0d, want valid=1 sum=%0d", sum_valid, sum_out, v);
    end
    tick();
  endtask

  task automatic test_clr();
    pulse(3'd1);
    pulse(3'd2);
    sample_en = 1'b1; sample_in = 3'd6;
    tick();
    sample_en = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || sum_valid !== 1'b0 || overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_idle: got busy=%b valid=%b ovr=%b, want 0 0 0", busy, sum_valid, overrun);
    end
    for (int i = 0; i < 4; i++) pulse(3'd2);
    n_cmp++;
    if (sum_valid !== 1'b1 || sum_out !== 5'd8) begin
      n_bad++;
      $display("FAIL clr_sum: got valid=%b sum=%0d, want valid=1 sum=8", sum_valid, sum_out);
    end
    tick();
  endtask

  task automatic test_async_reset();
    pulse(3'd3);
    pulse(3'd4);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({sum_valid, busy, overrun, sum_out} !== {1'b0, 1'b0, 1'b0, 5'd0}) begin
      n_bad++;
      $display("FAIL async_reset: got v=%b b=%b o=%b s=%0d, want all zero", sum_valid, busy, overrun, sum_out);
    end
    model_reset();
    sample_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (busy !== 1'b0 || sum_valid !== 1'b0 || sum_out !== 5'd0) begin
        n_bad++;
        $display("FAIL reset_release[%0d]: got busy=%b valid=%b sum=%0d, want 0 0 0", i, busy, sum_valid, sum_out);
      end
    end
    sample_en = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_first_cap: got busy=%b, want 1", busy);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      sample_en = 1'($urandom_range(0, 1));
      if (sample_en) sample_in = DATA_W'($urandom_range(0, 7));
      sum_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 31) == 0);
      tick();
      n_cmp++;
      if ({sum_valid, busy, overrun, sum_out} !== {m_valid, exp_busy(), m_ovr, SUM_W'(m_sum)}) begin
        n_bad++;
        $display("FAIL random[%0d]: got v=%b b=%b o=%b s=%0d, want v=%b b=%b o=%b s=%0d",
                 i, sum_valid, busy, overrun, sum_out, m_valid, exp_busy(), m_ovr, m_sum);
      end
    end
    clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_window();
    test_backpressure();
    test_back_to_back();
    test_held_enable();
    test_clr();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
